// File: rtl/dma_pkg.sv
// Shared definitions for the multi-channel DMA engine: register map, CTRL bit
// positions, sequencer states and beat-size helpers.
package dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_SIZE    = 1;
  localparam int CTRL_SRC_INC = 3;
  localparam int CTRL_DST_INC = 4;
  localparam int CTRL_CIRC    = 5;
  localparam int CTRL_IE      = 6;
  localparam int CTRL_DONE    = 8;
  localparam int CTRL_BUSY    = 9;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } dma_state_e;

  // Size code 3 has no wider beat behind it, so it behaves as a word.
  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_WORD : sz;
  endfunction

  function automatic logic [31:0] size_step(input logic [1:0] sz);
    case (eff_size(sz))
      SZ_BYTE: return 32'd1;
      SZ_HALF: return 32'd2;
      default: return 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// one past the winner whenever a grant is taken.
module dma_rr_arb
  import dma_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            cand;

  // Walk from the farthest candidate back to the pointer so the closest one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NCH;
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv && (gnt != '0)) ptr_d = IW'((int'(gnt_idx) + 1) % NCH);
  end

  always_ff @(posedge clk) begin
    if (!rstb) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel memory-to-memory DMA: per-channel register file on the c_* port,
// one shared d_* master port, one read+write beat per round-robin grant.
module dma_mc
  import dma_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int LENW = 16
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           c_valid,
  input  logic           c_write,
  input  logic [31:0]    c_addr,
  input  logic [1:0]     c_size,
  input  logic [31:0]    c_wdata,
  output logic           c_ready,
  output logic [31:0]    c_rdata,
  output logic           d_valid,
  output logic           d_write,
  output logic [31:0]    d_addr,
  output logic [1:0]     d_size,
  output logic [31:0]    d_wdata,
  input  logic [31:0]    d_rdata,
  input  logic           d_ready,
  output logic [NCH-1:0] irq
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  dma_state_e    state_q;
  logic [IW-1:0] act_q;
  logic          d_valid_q, d_write_q;
  logic [31:0]   d_addr_q, data_q;
  logic [1:0]    d_size_q;
  logic          c_ready_q;
  logic [31:0]   c_rdata_q, rd_val;

  logic [31:0]     src_all  [NCH];
  logic [31:0]     dst_all  [NCH];
  logic [31:0]     len_all  [NCH];
  logic [31:0]     ctrl_all [NCH];
  logic [1:0]      size_all [NCH];
  logic [NCH-1:0]  elig_q, elig_nxt, arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [2:0] cfg_ch;
  logic [1:0] cfg_reg;
  logic       cfg_ok, cfg_wr, beat_done;
  logic       unused_addr;

  assign cfg_ch      = c_addr[6:4];
  assign cfg_reg     = c_addr[3:2];
  assign cfg_ok      = c_valid && (c_size == SZ_WORD) && (int'(cfg_ch) < NCH);
  assign cfg_wr      = cfg_ok && c_write;
  assign unused_addr = ^{c_addr[31:7], c_addr[1:0]};
  assign beat_done   = (state_q == ST_WR) && d_ready;
  assign arb_any     = |arb_gnt;

  dma_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .clk     (clk),
    .rstb    (rstb),
    .req     (elig_q),
    .adv     (state_q == ST_ARB),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [31:0]     src_q, src_d, dst_q, dst_d, src0_q, src0_d, dst0_q, dst0_d;
    logic [LENW-1:0] len_q, len_d, len0_q, len0_d;
    logic [1:0]      size_q, size_d;
    logic            en_q, en_d, sinc_q, sinc_d, dinc_q, dinc_d;
    logic            circ_q, circ_d, ie_q, ie_d, done_q, done_d;
    logic            sel, busy, fin, last;
    logic [31:0]     ctrl_v;

    assign sel  = cfg_wr && (cfg_ch == 3'(i));
    assign busy = en_q && (len_q != '0);
    assign fin  = beat_done && (act_q == IW'(i));
    assign last = fin && (len_q == LENW'(1));

    // Beat completion is applied first; a same-cycle config write then overrides it.
    always_comb begin
      src_d  = src_q;  dst_d  = dst_q;  len_d  = len_q;
      src0_d = src0_q; dst0_d = dst0_q; len0_d = len0_q;
      size_d = size_q; en_d   = en_q;   sinc_d = sinc_q;
      dinc_d = dinc_q; circ_d = circ_q; ie_d   = ie_q; done_d = done_q;
      if (fin) begin
        src_d = src_q + (sinc_q ? size_step(size_q) : 32'd0);
        dst_d = dst_q + (dinc_q ? size_step(size_q) : 32'd0);
        len_d = len_q - LENW'(1);
        if (last) begin
          done_d = 1'b1;
          if (circ_q) begin
            src_d = src0_q;
            dst_d = dst0_q;
            len_d = len0_q;
          end else begin
            en_d = 1'b0;
          end
        end
      end
      if (sel) begin
        case (cfg_reg)
          REG_SRC: if (!busy) src_d = c_wdata;
          REG_DST: if (!busy) dst_d = c_wdata;
          REG_LEN: if (!busy) len_d = c_wdata[LENW-1:0];
          REG_CTRL: begin
            size_d = c_wdata[CTRL_SIZE +: 2];
            sinc_d = c_wdata[CTRL_SRC_INC];
            dinc_d = c_wdata[CTRL_DST_INC];
            circ_d = c_wdata[CTRL_CIRC];
            ie_d   = c_wdata[CTRL_IE];
            if (c_wdata[CTRL_DONE] && !last) done_d = 1'b0;
            if (!c_wdata[CTRL_EN]) begin
              en_d = 1'b0;
            end else if (len_d == '0) begin
              en_d   = 1'b0;
              done_d = 1'b1;
            end else begin
              // Shadow only on a fresh start so rewriting CTRL mid-run keeps the reload point.
              if (!en_d) begin
                src0_d = src_d;
                dst0_d = dst_d;
                len0_d = len_d;
              end
              en_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rstb) begin
        src_q  <= '0; dst_q  <= '0; len_q  <= '0;
        src0_q <= '0; dst0_q <= '0; len0_q <= '0;
        size_q <= '0; en_q   <= 1'b0; sinc_q <= 1'b0; dinc_q <= 1'b0;
        circ_q <= 1'b0; ie_q <= 1'b0; done_q <= 1'b0;
      end else begin
        src_q  <= src_d;  dst_q  <= dst_d;  len_q  <= len_d;
        src0_q <= src0_d; dst0_q <= dst0_d; len0_q <= len0_d;
        size_q <= size_d; en_q   <= en_d;   sinc_q <= sinc_d; dinc_q <= dinc_d;
        circ_q <= circ_d; ie_q   <= ie_d;   done_q <= done_d;
      end
    end

    always_comb begin
      ctrl_v                 = '0;
      ctrl_v[CTRL_EN]        = en_q;
      ctrl_v[CTRL_SIZE +: 2] = size_q;
      ctrl_v[CTRL_SRC_INC]   = sinc_q;
      ctrl_v[CTRL_DST_INC]   = dinc_q;
      ctrl_v[CTRL_CIRC]      = circ_q;
      ctrl_v[CTRL_IE]        = ie_q;
      ctrl_v[CTRL_DONE]      = done_q;
      ctrl_v[CTRL_BUSY]      = busy;
    end

    assign src_all[i]  = src_q;
    assign dst_all[i]  = dst_q;
    assign len_all[i]  = 32'(len_q);
    assign ctrl_all[i] = ctrl_v;
    assign size_all[i] = size_q;
    assign elig_q[i]   = busy;
    assign elig_nxt[i] = en_d && (len_d != '0);
    assign irq[i]      = done_q & ie_q;
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == 3'(i)) begin
        case (cfg_reg)
          REG_SRC: rd_val = src_all[i];
          REG_DST: rd_val = dst_all[i];
          REG_LEN: rd_val = len_all[i];
          default: rd_val = ctrl_all[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      c_ready_q <= 1'b0;
      c_rdata_q <= '0;
    end else begin
      c_ready_q <= c_valid;
      c_rdata_q <= (cfg_ok && !c_write) ? rd_val : 32'd0;
    end
  end

  // Sequencer
  // state   | meaning
  // IDLE    | no eligible channel, bus quiet
  // ARB     | one cycle, pick next channel round-robin, d_valid low
  // RD      | read beat from SRC of the active channel
  // WR      | write captured data to DST, then update channel counters
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      act_q     <= '0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_addr_q  <= '0;
      d_size_q  <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|elig_q) state_q <= ST_ARB;
        ST_ARB: begin
          if (arb_any) begin
            act_q     <= arb_idx;
            d_valid_q <= 1'b1;
            d_write_q <= 1'b0;
            d_addr_q  <= src_all[arb_idx];
            d_size_q  <= eff_size(size_all[arb_idx]);
            state_q   <= ST_RD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (d_ready) begin
            data_q    <= d_rdata;
            d_write_q <= 1'b1;
            d_addr_q  <= dst_all[act_q];
            state_q   <= ST_WR;
          end
        end
        ST_WR: begin
          if (d_ready) begin
            d_valid_q <= 1'b0;
            d_write_q <= 1'b0;
            state_q   <= (|elig_nxt) ? ST_ARB : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign c_ready = c_ready_q;
  assign c_rdata = c_rdata_q;
  assign d_valid = d_valid_q;
  assign d_write = d_write_q;
  assign d_addr  = d_addr_q;
  assign d_size  = d_size_q;
  assign d_wdata = data_q;

endmodule

// File: tb/tb_dma_mc.sv
// Self-checking bench for dma_mc: expected bus beats are queued when a transfer
// is configured and compared in order as the master port completes them.
module tb_dma_mc;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           c_valid = 1'b0, c_write = 1'b0;
  logic [31:0]    c_addr = '0, c_wdata = '0;
  logic [1:0]     c_size = 2'd2;
  logic           c_ready;
  logic [31:0]    c_rdata;
  logic           d_valid, d_write;
  logic [31:0]    d_addr, d_wdata, d_rdata;
  logic [1:0]     d_size;
  logic           d_ready = 1'b1;
  logic [NCH-1:0] irq;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  dma_mc #(.NCH(NCH), .LENW(16)) dut (
    .clk(clk), .rstb(rstb),
    .c_valid(c_valid), .c_write(c_write), .c_addr(c_addr), .c_size(c_size),
    .c_wdata(c_wdata), .c_ready(c_ready), .c_rdata(c_rdata),
    .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  assign d_rdata = mem_data(d_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] s, input logic [31:0] d, input logic [1:0] sz);
    exp_q.push_back('{wr: 1'b0, addr: s, data: 32'd0, size: sz});
    exp_q.push_back('{wr: 1'b1, addr: d, data: mem_data(s), size: sz});
  endtask

  always @(negedge clk) begin
    if (rstb && d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", d_addr, 32'hFFFF_FFFF ^ d_addr);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_dir", {31'd0, d_write}, {31'd0, e.wr});
        chk("beat_addr", d_addr, e.addr);
        chk("beat_size", {30'd0, d_size}, {30'd0, e.size});
        if (e.wr) chk("beat_wdata", d_wdata, e.data);
      end
    end
  end

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    c_valid = 1'b1; c_write = 1'b1; c_addr = a; c_wdata = d; c_size = 2'd2;
    @(negedge clk);
    c_valid = 1'b0; c_write = 1'b0;
  endtask

  task automatic cfg_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    c_valid = 1'b1; c_write = 1'b0; c_addr = a; c_size = 2'd2;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, c_ready}, 32'd1);
    chk(tag, c_rdata, exp);
    c_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 d_ready = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0; c_valid = 1'b0; c_write = 1'b0; d_ready = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rstb = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || d_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, {31'd0, n < 400}, 32'd1);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Wait for irq[ch], then stall the slave just as the next read beat opens.
  task automatic stall_after_irq(input int ch, input string tag);
    int n;
    n = 0;
    while (!irq[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_irq_seen"}, {31'd0, irq[ch]}, 32'd1);
    set_ready(1'b0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_d_write", {31'd0, d_write}, 32'd0);
    chk("rst_c_ready", {31'd0, c_ready}, 32'd0);
    chk("rst_irq", {28'd0, irq}, 32'd0);
    chk("rst_d_addr", d_addr, 32'd0);
    chk("rst_d_wdata", d_wdata, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);

    // 1: single word transfer with both addresses incrementing
    for (int k = 0; k < 4; k++) push_beat(32'h100 + 32'(4 * k), 32'h200 + 32'(4 * k), 2'd2);
    cfg_wr(32'h00, 32'h100);
    cfg_wr(32'h04, 32'h200);
    cfg_wr(32'h08, 32'd4);
    cfg_wr(32'h0C, 32'h1D);
    wait_idle("t1");
    cfg_chk("t1_ctrl", 32'h0C, 32'h11C);
    cfg_chk("t1_len", 32'h08, 32'd0);
    cfg_chk("t1_src", 32'h00, 32'h110);
    cfg_chk("t1_dst", 32'h04, 32'h210);
    chk("t1_irq", {28'd0, irq}, 32'd0);

    // 2: two channels interleave one beat per grant
    do_reset();
    push_beat(32'h1000, 32'h5000, 2'd2);
    push_beat(32'h3000, 32'h7000, 2'd2);
    push_beat(32'h1004, 32'h5004, 2'd2);
    push_beat(32'h3004, 32'h7004, 2'd2);
    cfg_wr(32'h00, 32'h1000); cfg_wr(32'h04, 32'h5000); cfg_wr(32'h08, 32'd2);
    cfg_wr(32'h20, 32'h3000); cfg_wr(32'h24, 32'h7000); cfg_wr(32'h28, 32'd2);
    cfg_wr(32'h0C, 32'h1D);
    cfg_wr(32'h2C, 32'h1D);
    wait_idle("t2");
    cfg_chk("t2_ctrl0", 32'h0C, 32'h11C);
    cfg_chk("t2_ctrl2", 32'h2C, 32'h11C);

    // 3: byte beats, source wraps through zero, fixed destination
    do_reset();
    push_beat(32'hFFFF_FFFF, 32'h40, 2'd0);
    push_beat(32'h0000_0000, 32'h40, 2'd0);
    cfg_wr(32'h10, 32'hFFFF_FFFF); cfg_wr(32'h14, 32'h40); cfg_wr(32'h18, 32'd2);
    cfg_wr(32'h1C, 32'h09);
    wait_idle("t3");
    cfg_chk("t3_src", 32'h10, 32'h1);
    cfg_chk("t3_dst", 32'h14, 32'h40);

    // 4: slave stall with an abort landing mid-beat
    do_reset();
    push_beat(32'h500, 32'h600, 2'd2);
    cfg_wr(32'h10, 32'h500); cfg_wr(32'h14, 32'h600); cfg_wr(32'h18, 32'd3);
    d_ready = 1'b0;
    cfg_wr(32'h1C, 32'h1D);
    begin
      int n;
      n = 0;
      while (!d_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_rd_started", {31'd0, d_valid}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, d_valid}, 32'd1);
      chk("t4_hold_addr", d_addr, 32'h500);
    end
    cfg_wr(32'h1C, 32'h1C);
    chk("t4_abort_valid", {31'd0, d_valid}, 32'd1);
    chk("t4_abort_addr", d_addr, 32'h500);
    chk("t4_abort_write", {31'd0, d_write}, 32'd0);
    set_ready(1'b1);
    wait_idle("t4");
    cfg_chk("t4_len", 32'h18, 32'd2);
    cfg_chk("t4_ctrl", 32'h1C, 32'h1C);

    // 5: circular mode with interrupt, reload, W1C and continued traffic
    do_reset();
    for (int k = 0; k < 5; k++) push_beat(32'h800 + 32'(4 * (k % 2)), 32'h900 + 32'(4 * (k % 2)), 2'd2);
    cfg_wr(32'h30, 32'h800); cfg_wr(32'h34, 32'h900); cfg_wr(32'h38, 32'd2);
    cfg_wr(32'h3C, 32'h7D);
    stall_after_irq(3, "t5a");
    chk("t5_rd_addr", d_addr, 32'h800);
    cfg_chk("t5_src_reload", 32'h30, 32'h800);
    cfg_chk("t5_len_reload", 32'h38, 32'd2);
    cfg_wr(32'h3C, 32'h17D);
    chk("t5_irq_clear", {28'd0, irq}, 32'd0);
    set_ready(1'b1);
    stall_after_irq(3, "t5b");
    chk("t5_rd2_addr", d_addr, 32'h800);
    cfg_wr(32'h3C, 32'h7C);
    set_ready(1'b1);
    wait_idle("t5");
    cfg_chk("t5_len", 32'h38, 32'd1);
    cfg_chk("t5_src", 32'h30, 32'h804);
    cfg_chk("t5_ctrl", 32'h3C, 32'h17C);
    chk("t5_irq_final", {28'd0, irq}, 32'h8);

    // 6: zero-length start, ignored accesses, busy write protection, reset mid-write
    do_reset();
    cfg_wr(32'h0C, 32'h45);
    chk("t6_irq_done", {28'd0, irq}, 32'h1);
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_traffic", {31'd0, d_valid}, 32'd0);
    end
    cfg_chk("t6_ctrl0", 32'h0C, 32'h144);
    cfg_wr(32'h50, 32'h1234);
    cfg_chk("t6_ch5_read", 32'h50, 32'd0);
    cfg_chk("t6_ch1_alias", 32'h10, 32'd0);
    @(negedge clk);
    c_valid = 1'b1; c_write = 1'b1; c_addr = 32'h10; c_wdata = 32'h55; c_size = 2'd1;
    @(negedge clk);
    c_valid = 1'b0; c_write = 1'b0; c_size = 2'd2;
    cfg_chk("t6_bad_size", 32'h10, 32'd0);
    push_beat(32'hA00, 32'hB00, 2'd2);
    cfg_wr(32'h10, 32'hA00); cfg_wr(32'h14, 32'hB00); cfg_wr(32'h18, 32'd3);
    d_ready = 1'b0;
    cfg_wr(32'h1C, 32'h1D);
    cfg_wr(32'h10, 32'hDEAD_0000);
    cfg_chk("t6_busy_src", 32'h10, 32'hA00);
    chk("t6_rd_wait", {31'd0, d_valid}, 32'd1);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    chk("t6_in_wr", {31'd0, d_write}, 32'd1);
    chk("t6_wr_addr", d_addr, 32'hB00);
    rstb = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, d_valid}, 32'd0);
    chk("t6_rst_write", {31'd0, d_write}, 32'd0);
    chk("t6_rst_addr", d_addr, 32'd0);
    chk("t6_rst_wdata", d_wdata, 32'd0);
    chk("t6_rst_irq", {28'd0, irq}, 32'd0);
    exp_q.delete();
    d_ready = 1'b1;
    @(negedge clk);
    rstb = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_post_rst_quiet", {31'd0, d_valid}, 32'd0);
    end
    cfg_chk("t6_post_rst_src", 32'h10, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
